// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int num_digits(int width, int digit);
        return width / digit;
    endfunction

    function automatic int cnt_width(int width, int digit);
        return $clog2(width / digit + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand and result valid/ready channels of serial_addsub.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cb;
    logic             ovf;

    modport master (
        output in_valid, a, b, mode, out_ready,
        input  in_ready, out_valid, result, cb, ovf
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready,
        output in_ready, out_valid, result, cb, ovf
    );
endinterface

// File: rtl/serial_addsub_digit_addsub.sv
// Combinational DIGIT-bit ripple of full-adder cells.
module digit_addsub #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    always_comb begin : ripple
        logic c;
        // NOTE: blocking assignments here so each cell sees the carry the
        // previous cell just produced within the same evaluation.
        c = cin;
        s = '0;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract, DIGIT bits per cycle LSB first.
// Define SERIAL_ADDSUB_SAT_EN for unsigned saturation of the result.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             cb_raw, ovf_raw, done;
    logic [WIDTH-1:0] res_out;

    digit_addsub #(.DIGIT(DIGIT)) u_digit (
        .x    (a_q[DIGIT-1:0]),
        .y    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_sum),
        .cout (dig_cout)
    );

    // NOTE: non-blocking assignments for every register so all state
    // updates see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            mode_q   <= MODE_ADD;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            mode_q   <= mode_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        mode_d   = mode_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                    carry_d  = bus.mode;
                    mode_d   = bus.mode;
                    cnt_d    = '0;
                    res_d    = '0;
                    sign_a_d = bus.a[WIDTH-1];
                    sign_b_d = b_d[WIDTH-1];
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                res_d   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are gated by DONE so a partial RUN result is never visible.
    assign done    = (state_q == DONE);
    assign cb_raw  = (mode_q == MODE_SUB) ? ~carry_q : carry_q;
    assign ovf_raw = (sign_a_q == sign_b_q) && (res_q[WIDTH-1] != sign_a_q);

`ifdef SERIAL_ADDSUB_SAT_EN
    assign res_out = cb_raw ? ((mode_q == MODE_ADD) ? '1 : '0) : res_q;
`else
    assign res_out = res_q;
`endif

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = done;
    assign bus.result    = done ? res_out : '0;
    assign bus.cb        = done & cb_raw;
    assign bus.ovf       = done & ovf_raw;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: DIGIT=1 and DIGIT=4 instances driven in lockstep.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8)) bus1 ();
    serial_addsub_if #(.WIDTH(8)) bus4 ();

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {cb, ovf, result}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int raw = m ? ua - ub : ua + ub;
        int sr  = m ? sa - sb : sa + sb;
        logic cbv = m ? (ua < ub) : (raw > 255);
        logic ov  = (sr > 127) || (sr < -128);
        logic [7:0] r = 8'(raw & 255);
`ifdef SERIAL_ADDSUB_SAT_EN
        if (cbv) r = m ? 8'h00 : 8'hFF;
`endif
        return {cbv, ov, r};
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic m);
        bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.mode = m;
        bus4.in_valid = v; bus4.a = a; bus4.b = b; bus4.mode = m;
    endtask

    task automatic set_out_ready(input logic r);
        bus1.out_ready = r;
        bus4.out_ready = r;
    endtask

    task automatic check_result(input string tag, input logic [9:0] e);
        check({tag, "_res1"}, 32'(bus1.result), 32'(e[7:0]));
        check({tag, "_cb1"},  32'(bus1.cb),     32'(e[9]));
        check({tag, "_ovf1"}, 32'(bus1.ovf),    32'(e[8]));
        check({tag, "_res4"}, 32'(bus4.result), 32'(e[7:0]));
        check({tag, "_cb4"},  32'(bus4.cb),     32'(e[9]));
        check({tag, "_ovf4"}, 32'(bus4.ovf),    32'(e[8]));
    endtask

    // One operation on both instances; hold = cycles of out_ready low in DONE.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input int hold, input string tag);
        logic [9:0] e;
        int lat1;
        int lat4;
        e    = model(a, b, m);
        lat1 = -1;
        lat4 = -1;
        @(negedge clk);
        check({tag, "_idle_rdy"}, 32'(bus1.in_ready), 32'd1);
        drive(1'b1, a, b, m);
        @(posedge clk);
        #1;
        drive(1'b0, 8'($urandom), 8'($urandom), ~m);
        check({tag, "_busy1"}, 32'(bus1.in_ready), 32'd0);
        check({tag, "_busy4"}, 32'(bus4.in_ready), 32'd0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (lat1 < 0 && bus1.out_valid) lat1 = c;
            if (lat4 < 0 && bus4.out_valid) lat4 = c;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
        check({tag, "_lat1"}, 32'(lat1), 32'd8);
        check({tag, "_lat4"}, 32'(lat4), 32'd2);
        check_result(tag, e);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            check({tag, "_hold_vld"}, 32'(bus1.out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(bus1.in_ready), 32'd0);
            check_result({tag, "_hold"}, e);
        end
        @(negedge clk);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        set_out_ready(1'b1);
        @(posedge clk);
        #1;
        check({tag, "_drop1"}, 32'(bus1.out_valid), 32'd0);
        check({tag, "_drop4"}, 32'(bus4.out_valid), 32'd0);
        check({tag, "_back1"}, 32'(bus1.in_ready), 32'd1);
        check({tag, "_back4"}, 32'(bus4.in_ready), 32'd1);
        @(negedge clk);
        set_out_ready(1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        set_out_ready(1'b0);
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus1.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst_result",    32'(bus1.result),    32'd0);
        check("rst_cb",        32'(bus1.cb),        32'd0);
        check("rst_ovf",       32'(bus1.ovf),       32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus1.in_ready), 32'd1);

        run_op(8'h3C, 8'h45, MODE_ADD, 0, "add_3c_45");
        run_op(8'hFF, 8'h01, MODE_ADD, 0, "add_ff_01");
        run_op(8'h05, 8'h07, MODE_SUB, 0, "sub_05_07");
        run_op(8'h80, 8'h01, MODE_SUB, 0, "sub_80_01");
        run_op(8'($urandom), 8'($urandom), 1'($urandom), 5, "backpressure");

        // Abort: dut1 is mid-RUN and dut4 already sits in DONE.
        @(negedge clk);
        drive(1'b1, 8'h5A, 8'h33, MODE_ADD);
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_pre_vld4", 32'(bus4.out_valid), 32'd1);
        check("abort_pre_vld1", 32'(bus1.out_valid), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_vld1", 32'(bus1.out_valid), 32'd0);
        check("abort_res1", 32'(bus1.result),    32'd0);
        check("abort_rdy1", 32'(bus1.in_ready),  32'd0);
        check("abort_vld4", 32'(bus4.out_valid), 32'd0);
        check("abort_res4", 32'(bus4.result),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h10, 8'h20, MODE_ADD, 0, "after_abort");

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
